// File: rtl/processor_pkg.sv
// Shared types and constants for the multicycle processor control path.
// Holds the sequencer state enum, phase encodings and default reset-strobe length.
package processor_pkg;

   typedef enum logic [2:0] {
      INIT = 3'd0,
      STOP = 3'd1,
      P1   = 3'd2,
      P2   = 3'd3,
      P3   = 3'd4,
      P4   = 3'd5,
      P5   = 3'd6
   } state_t;

   localparam logic [2:0] PH_IDLE = 3'd0;
   localparam logic [2:0] PH_1    = 3'd1;
   localparam logic [2:0] PH_2    = 3'd2;
   localparam logic [2:0] PH_3    = 3'd3;
   localparam logic [2:0] PH_4    = 3'd4;
   localparam logic [2:0] PH_5    = 3'd5;

   localparam int REG_RESET_CYCLES_DEF = 2;

   function automatic logic [2:0] phase_of(input state_t s);
      case (s)
         P1:      return PH_1;
         P2:      return PH_2;
         P3:      return PH_3;
         P4:      return PH_4;
         P5:      return PH_5;
         default: return PH_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/phase_sequencer_rise_detect.sv
// Single-bit rising-edge detector with a configurable reset value for the history flop.
// A reset value of 1 keeps an input held through reset from registering as an edge.
module rise_detect #(
   parameter logic RESET_VALUE = 1'b1
) (
   input  logic clock,
   input  logic reset,
   input  logic level,
   output logic rise
);

   logic level_q;

   // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) level_q <= RESET_VALUE;
      else        level_q <= level;
   end

   assign rise = level & ~level_q;

endmodule

// File: rtl/phase_sequencer.sv
// Run/stop phase sequencer: INIT -> STOP -> P1..P5 with halt, exec stop and P2 wait states.
// Build option SINGLE_STEP_EN adds input step_mode, which forces P5 to STOP on every instruction.
module phase_sequencer
   import processor_pkg::*;
#(
   parameter int REG_RESET_CYCLES = REG_RESET_CYCLES_DEF,
   parameter int COUNT_W          = 16
) (
   input  logic               clock,
   input  logic               reset,
`ifdef SINGLE_STEP_EN
   input  logic               step_mode,
`endif
   input  logic               exec,
   input  logic               halt_req,
   input  logic               mem_wait,
   output logic [2:0]         phase,
   output logic               p1,
   output logic               p2,
   output logic               p3,
   output logic               p4,
   output logic               p5,
   output logic               running,
   output logic               register_reset,
   output logic [COUNT_W-1:0] instr_count
);

   localparam int INIT_W = (REG_RESET_CYCLES > 1) ? $clog2(REG_RESET_CYCLES) : 1;
   localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(REG_RESET_CYCLES - 1);

   state_t              state;
   state_t              state_next;
   logic [INIT_W-1:0]   init_cnt;
   logic                stop_pending;
   logic                exec_rise;
   logic                step;
   logic                stop_now;

`ifdef SINGLE_STEP_EN
   assign step = step_mode;
`else
   assign step = 1'b0;
`endif

   rise_detect #(.RESET_VALUE(1'b1)) u_exec_rise (
      .clock (clock),
      .reset (reset),
      .level (exec),
      .rise  (exec_rise)
   );

   assign stop_now = halt_req | stop_pending | exec_rise | step;

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         INIT:    if (init_cnt == INIT_LAST) state_next = STOP;
         STOP:    if (exec_rise) state_next = P1;
         P1:      state_next = P2;
         P2:      if (!mem_wait) state_next = P3;
         P3:      state_next = P4;
         P4:      state_next = P5;
         P5:      state_next = stop_now ? STOP : P1;
         default: state_next = INIT;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= INIT;
         init_cnt     <= '0;
         stop_pending <= 1'b0;
         instr_count  <= '0;
      end else begin
         state <= state_next;
         if (state == INIT) init_cnt <= init_cnt + 1'b1;
         // A stop request made mid-instruction is remembered until the instruction retires.
         if (state_next == STOP)
            stop_pending <= 1'b0;
         else if (exec_rise && (state inside {P1, P2, P3, P4}))
            stop_pending <= 1'b1;
         if (state == P5) instr_count <= instr_count + 1'b1;
      end
   end

   assign phase          = phase_of(state);
   assign p1             = (state == P1);
   assign p2             = (state == P2);
   assign p3             = (state == P3);
   assign p4             = (state == P4);
   assign p5             = (state == P5);
   assign running        = (phase != PH_IDLE);
   assign register_reset = (state == INIT);

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: driver pushes model predictions, monitor pops and compares.
// Covers reset strobe, run loop, P2 wait states, halt, exec stop, held exec and mid-instruction reset.
module tb_phase_sequencer;

   localparam int RRC = 2;
   localparam int CW  = 16;

   typedef struct {
      int          ph;
      logic        rr;
      logic [CW-1:0] cnt;
   } exp_t;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          exec = 1'b0;
   logic          halt_req = 1'b0;
   logic          mem_wait = 1'b0;
`ifdef SINGLE_STEP_EN
   logic          step_mode = 1'b0;
`endif
   logic [2:0]    phase;
   logic          p1, p2, p3, p4, p5;
   logic          running;
   logic          register_reset;
   logic [CW-1:0] instr_count;

   int n_compared = 0;
   int n_mismatched = 0;

   exp_t exp_q[$];

   // Reference model state: phase number 0..5 plus an "in init" countdown.
   int            m_phase;
   int            m_init_left;
   logic          m_prev_exec;
   logic          m_pend;
   logic [CW-1:0] m_count;

   always #5 clock = ~clock;

   phase_sequencer #(.REG_RESET_CYCLES(RRC), .COUNT_W(CW)) dut (
      .clock          (clock),
      .reset          (reset),
`ifdef SINGLE_STEP_EN
      .step_mode      (step_mode),
`endif
      .exec           (exec),
      .halt_req       (halt_req),
      .mem_wait       (mem_wait),
      .phase          (phase),
      .p1             (p1),
      .p2             (p2),
      .p3             (p3),
      .p4             (p4),
      .p5             (p5),
      .running        (running),
      .register_reset (register_reset),
      .instr_count    (instr_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_compared++;
      if (act !== req) begin
         n_mismatched++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      m_phase     = 0;
      m_init_left = RRC;
      m_prev_exec = 1'b1;
      m_pend      = 1'b0;
      m_count     = '0;
   endtask

   task automatic model_step(input logic e, input logic h, input logic m, input logic s);
      logic rise;
      rise = e && !m_prev_exec;
      m_prev_exec = e;
      if (m_init_left > 0) begin
         m_init_left--;
      end else if (m_phase == 0) begin
         if (rise) m_phase = 1;
      end else if (m_phase == 5) begin
         m_count++;
         if (h || m_pend || rise || s) begin
            m_phase = 0;
            m_pend  = 1'b0;
         end else begin
            m_phase = 1;
         end
      end else begin
         if (rise) m_pend = 1'b1;
         if (!(m_phase == 2 && m)) m_phase++;
      end
   endtask

   // Called at a falling edge: drive inputs, predict the next rising edge, wait one cycle.
   task automatic cycle(input logic e, input logic h, input logic m, input logic s);
      exp_t x;
      exec     = e;
      halt_req = h;
      mem_wait = m;
`ifdef SINGLE_STEP_EN
      step_mode = s;
`endif
      model_step(e, h, m, s);
      x.ph  = m_phase;
      x.rr  = (m_init_left > 0);
      x.cnt = m_count;
      exp_q.push_back(x);
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic run_until(input int target);
      int n = 0;
      while (m_phase != target && n < 64) begin
         cycle(1'b0, 1'b0, 1'b0, 1'b0);
         n++;
      end
      check("run_until_bound", m_phase, target);
   endtask

   // Called at a falling edge; leaves reset released at a falling edge.
   task automatic do_reset(input int n);
      reset = 1'b0;
      #1;
      check("rst_phase", phase, 0);
      check("rst_strobes", {p5, p4, p3, p2, p1}, 0);
      check("rst_running", running, 0);
      check("rst_count", instr_count, 0);
      check("rst_regreset", register_reset, 1);
      model_reset();
      repeat (n) @(negedge clock);
      reset = 1'b1;
   endtask

   // Monitor: every rising edge the DUT presents a new state; compare against the oldest prediction.
   always @(posedge clock) begin
      exp_t x;
      logic [4:0] exp_p;
      #2;
      if (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         exp_p = (x.ph == 0) ? 5'b0 : (5'b1 << (x.ph - 1));
         check("phase", phase, x.ph);
         check("strobes", {p5, p4, p3, p2, p1}, exp_p);
         check("running", running, (x.ph != 0));
         check("register_reset", register_reset, x.rr);
         check("instr_count", instr_count, x.cnt);
      end
   end

   initial begin
      logic e, h, m, s;
      int guard;
      model_reset();
      @(negedge clock);
      do_reset(3);
      idle(4);

      // Start from STOP, then free-run one full instruction and into the next P1.
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      idle(5);

      // Three wait cycles at P2 entry stretch P2 to four cycles.
      run_until(2);
      repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b0);
      idle(2);

      // Halt in P5 stops; halt outside P5 is ignored.
      run_until(5);
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      idle(3);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      run_until(3);
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      idle(3);

      // Exec during P3 finishes the instruction then stops; exec in P5 stops directly.
      run_until(3);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      idle(5);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      run_until(5);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      idle(3);

      // Exec held through reset release must not start the machine.
      exec = 1'b1;
      do_reset(2);
      repeat (8) cycle(1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);

      // Run to count 7 in P3, then reset mid-instruction.
      guard = 0;
      while (!(m_count == 7 && m_phase == 3) && guard < 100) begin
         cycle(1'b0, 1'b0, 1'b0, 1'b0);
         guard++;
      end
      check("reach_count7_p3", m_count, 7);
      exec = 1'b0;
      do_reset(2);
      idle(4);

      // Randomised traffic with occasional resets.
      for (int i = 0; i < 1500; i++) begin
         e = ($urandom_range(0, 3) == 0);
         h = ($urandom_range(0, 7) == 0);
         m = ($urandom_range(0, 2) == 0);
`ifdef SINGLE_STEP_EN
         s = ($urandom_range(0, 3) == 0);
`else
         s = 1'b0;
`endif
         if (i % 500 == 499) do_reset($urandom_range(1, 3));
         cycle(e, h, m, s);
      end

      check("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
